// File: rtl/rf_access_sched.sv
// rf_access_sched: write-buffered, hazard-aware access scheduler for a single-op-per-cycle register file
module rf_access_sched #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int WBUF_DEPTH = 4,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RD_REQ,
  input  logic [AW-1:0]                RD_ADDR1,
  input  logic [AW-1:0]                RD_ADDR2,
  output logic                         RD_GNT,
  output logic                         RD_VALID,
  output logic [DW-1:0]                RD_DATA1,
  output logic [DW-1:0]                RD_DATA2,
  input  logic                         WR_REQ,
  input  logic [AW-1:0]                WR_ADDR,
  input  logic [DW-1:0]                WR_DATA,
  output logic                         WR_GNT,
  output logic [$clog2(WBUF_DEPTH):0]  WBUF_CNT,
  output logic                         RF_READ,
  output logic                         RF_WRITE,
  output logic [AW-1:0]                RF_ADDR_R1,
  output logic [AW-1:0]                RF_ADDR_R2,
  output logic [AW-1:0]                RF_ADDR_W,
  output logic [DW-1:0]                RF_DATA_W,
  input  logic [DW-1:0]                RF_DATA_R1,
  input  logic [DW-1:0]                RF_DATA_R2
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_CAPT} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       buf_addr [WBUF_DEPTH];
  logic [DW-1:0]       buf_data [WBUF_DEPTH];
  logic [PW-1:0]       head, tail;
  logic [PW:0]         cnt, eff_cnt;
  logic [SW-1:0]       streak, streak_nxt;
  logic [AW-1:0]       ra1, ra2;
  logic [WBUF_DEPTH-1:0] hit;
  logic                hazard, force_wr, deq, enq;

  assign deq      = state == WR;
  assign WR_GNT   = cnt < (PW+1)'(WBUF_DEPTH);
  assign enq      = WR_REQ && WR_GNT;
  assign eff_cnt  = cnt - (PW+1)'(deq);
  assign WBUF_CNT = cnt;

  // an entry is live if it lies within count of head; the head is already gone when it retires this edge
  for (genvar i = 0; i < WBUF_DEPTH; i++) begin : g_hit
    logic [PW-1:0] off;
    assign off    = PW'(i) - head;
    assign hit[i] = ({1'b0, off} < cnt) && !(deq && off == '0) &&
                    (buf_addr[i] == RD_ADDR1 || buf_addr[i] == RD_ADDR2);
  end

  assign hazard   = |hit;
  assign force_wr = !WR_GNT || (streak == SW'(MAX_RD_STREAK) && eff_cnt != '0);

  // state and read-streak registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // arbitration: grant a read unless it hits a pending write or writes must drain first
  always_comb begin
    RD_GNT     = state != RD_ISSUE && RD_REQ && !hazard && !force_wr;
    state_nxt  = state == RD_ISSUE ? RD_CAPT :
                 RD_GNT            ? RD_ISSUE :
                 eff_cnt != '0     ? WR : IDLE;
    streak_nxt = state == RD_ISSUE ? streak :
                 RD_GNT            ? streak + SW'(eff_cnt != '0) :
                 eff_cnt != '0     ? '0 : streak;
  end

  // write buffer pointers and occupancy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      cnt <= cnt + (PW+1)'(enq) - (PW+1)'(deq);
    end
  end

  // write buffer storage; contents are meaningless outside the live window so need no reset
  always_ff @(posedge CLK) begin
    if (enq) begin
      buf_addr[tail] <= WR_ADDR;
      buf_data[tail] <= WR_DATA;
    end
  end

  // latch granted read addresses and capture file data at the end of the capture cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ra1      <= '0;
      ra2      <= '0;
      RD_VALID <= 1'b0;
      RD_DATA1 <= '0;
      RD_DATA2 <= '0;
    end else begin
      if (RD_GNT) begin
        ra1 <= RD_ADDR1;
        ra2 <= RD_ADDR2;
      end
      RD_VALID <= state == RD_CAPT;
      if (state == RD_CAPT) begin
        RD_DATA1 <= RF_DATA_R1;
        RD_DATA2 <= RF_DATA_R2;
      end
    end
  end

  // register-file control decoded from state; idle buses are held at zero
  always_comb begin
    RF_READ    = state == RD_ISSUE || state == RD_CAPT;
    RF_WRITE   = deq;
    RF_ADDR_R1 = RF_READ ? ra1 : '0;
    RF_ADDR_R2 = RF_READ ? ra2 : '0;
    RF_ADDR_W  = RF_WRITE ? buf_addr[head] : '0;
    RF_DATA_W  = RF_WRITE ? buf_data[head] : '0;
  end
endmodule
